// File: rtl/pixel_scale_div.sv
// Pops one pixel at a time from an upstream normal-mode FIFO and scales it by
// gain/denom using a 16-cycle restoring divider; the result is held until accepted.
module pixel_scale_div #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       aclr_n,
    input  logic       enable,
    input  logic [7:0] gain,
    input  logic [7:0] denom,
    input  logic [7:0] fifo_dataout,
    input  logic       fifo_empty,
    output logic       fifo_rdreq,
    output logic [7:0] out_data,
    output logic [7:0] out_remain,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sat,
    output logic       div0,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, WAIT, MUL, DIV, OUT} state_t;

    state_t      state, next_state;
    logic [7:0]  pixel_q, gain_q, denom_q;
    logic [15:0] product, quotient;
    logic [7:0]  remainder;
    logic [3:0]  step;

    logic [8:0]  trial;
    logic        trial_ge;
    logic [7:0]  rem_next;
    logic [15:0] quo_next;
    logic [7:0]  result_data;
    logic        result_sat;

    // One restoring step: bring down the next dividend bit MSB first, subtract if it fits.
    always_comb begin
        trial       = {remainder, product[4'd15 - step]};
        trial_ge    = (trial >= {1'b0, denom_q});
        rem_next    = trial_ge ? 8'(trial - {1'b0, denom_q}) : trial[7:0];
        quo_next    = {quotient[14:0], trial_ge};
        result_data = quo_next[7:0];
        result_sat  = 1'b0;
        if (SAT_EN && (quo_next[15:8] != 8'd0)) begin
            result_data = 8'hFF;
            result_sat  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) state <= IDLE;
        else         state <= next_state;
    end

    // NOTE: defaults first so no path through the case leaves an output
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        fifo_rdreq = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so nothing is popped while the FSM cannot capture it.
                if (aclr_n && enable && !fifo_empty) begin
                    fifo_rdreq = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: next_state = MUL;
            MUL:  next_state = (denom_q == 8'd0) ? OUT : DIV;
            DIV:  if (step == 4'd15) next_state = OUT;
            OUT:  if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    // NOTE: every datapath register is cleared on reset because reset must zero
    // both the visible result and the discarded in-flight pixel.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            pixel_q    <= '0;
            gain_q     <= '0;
            denom_q    <= '0;
            product    <= '0;
            quotient   <= '0;
            remainder  <= '0;
            step       <= '0;
            out_data   <= '0;
            out_remain <= '0;
            sat        <= 1'b0;
            div0       <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    pixel_q <= fifo_dataout;
                    gain_q  <= gain;
                    denom_q <= denom;
                end
                MUL: begin
                    product   <= 16'(pixel_q) * 16'(gain_q);
                    quotient  <= '0;
                    remainder <= '0;
                    step      <= '0;
                    if (denom_q == 8'd0) begin
                        out_data   <= 8'hFF;
                        out_remain <= 8'h00;
                        sat        <= 1'b0;
                        div0       <= 1'b1;
                    end
                end
                DIV: begin
                    quotient  <= quo_next;
                    remainder <= rem_next;
                    step      <= step + 4'd1;
                    if (step == 4'd15) begin
                        out_data   <= result_data;
                        out_remain <= rem_next;
                        sat        <= result_sat;
                        div0       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_scale_div.sv
// Bench for pixel_scale_div: saturating and truncating instances share one
// stimulus stream and a queue-based upstream FIFO, checked against an arithmetic model.
module tb_pixel_scale_div;

    logic       clk = 1'b0;
    logic       aclr_n, enable, fifo_empty, out_ready;
    logic [7:0] gain, denom, fifo_dataout;
    logic       s_rdreq, s_valid, s_sat, s_div0, s_busy;
    logic       t_rdreq, t_valid, t_sat, t_div0, t_busy;
    logic [7:0] s_data, s_rem, t_data, t_rem;
    logic [7:0] fifo_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;

    always #5 clk = ~clk;

    pixel_scale_div #(.SAT_EN(1'b1)) dut_s (
        .clk(clk), .aclr_n(aclr_n), .enable(enable), .gain(gain), .denom(denom),
        .fifo_dataout(fifo_dataout), .fifo_empty(fifo_empty), .fifo_rdreq(s_rdreq),
        .out_data(s_data), .out_remain(s_rem), .out_valid(s_valid), .out_ready(out_ready),
        .sat(s_sat), .div0(s_div0), .busy(s_busy)
    );

    pixel_scale_div #(.SAT_EN(1'b0)) dut_t (
        .clk(clk), .aclr_n(aclr_n), .enable(enable), .gain(gain), .denom(denom),
        .fifo_dataout(fifo_dataout), .fifo_empty(fifo_empty), .fifo_rdreq(t_rdreq),
        .out_data(t_data), .out_remain(t_rem), .out_valid(t_valid), .out_ready(out_ready),
        .sat(t_sat), .div0(t_div0), .busy(t_busy)
    );

    // Advance one clock from a negedge to the next; the FIFO pops after the edge.
    task automatic cycle();
        logic rd;
        #1 rd = s_rdreq;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) fifo_dataout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    function automatic void model(input int p, input int g, input int d, input bit sat_en,
                                  output logic [7:0] data, output logic [7:0] rem,
                                  output bit s, output bit z);
        int prod;
        int q;
        prod = p * g;
        if (d == 0) begin
            data = 8'hFF; rem = 8'h00; s = 1'b0; z = 1'b1;
        end else begin
            q   = prod / d;
            rem = 8'(prod % d);
            z   = 1'b0;
            if (sat_en && q > 255) begin data = 8'hFF; s = 1'b1; end
            else                   begin data = 8'(q); s = 1'b0; end
        end
    endfunction

    task automatic do_pixel(input string name, input logic [7:0] p, input logic [7:0] g,
                            input logic [7:0] d, input int hold, input bit push, input bit drop_en);
        logic [7:0] es_data, et_data, e_rem, e_rem_t;
        bit         es_sat, et_sat, e_div0, e_div0_t, extra_rd, stable;
        int         n, lat, exp_lat;
        model(p, g, d, 1'b1, es_data, e_rem, es_sat, e_div0);
        model(p, g, d, 1'b0, et_data, e_rem_t, et_sat, e_div0_t);
        exp_lat = (d == 0) ? 3 : 19;
        if (push) begin fifo_q.push_back(p); fifo_empty = 1'b0; end
        gain = g; denom = d; enable = 1'b1; out_ready = (hold == 0);
        #1;
        n = 0;
        while (s_rdreq !== 1'b1 && n < 20) begin cycle(); #1; n++; end
        tests_run++;
        if (s_rdreq !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s rdreq: got %b expected 1", name, s_rdreq);
            return;
        end
        extra_rd = 1'b0;
        cycle(); lat = 1;
        if (s_rdreq !== 1'b0 || t_rdreq !== 1'b0) extra_rd = 1'b1;
        cycle(); lat = 2;
        // Inputs changed after capture must not disturb the pixel in flight.
        gain = 8'($urandom); denom = 8'($urandom);
        if (drop_en) enable = 1'b0;
        while (s_valid !== 1'b1 && lat < 40) begin
            if (s_rdreq !== 1'b0 || t_rdreq !== 1'b0 || s_busy !== 1'b1) extra_rd = 1'b1;
            cycle(); lat++;
        end
        tests_run++;
        if (lat != exp_lat) begin tests_failed++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
        tests_run++;
        if (extra_rd) begin tests_failed++; $display("FAIL %s busy_rdreq: got rdreq/busy glitch expected rdreq 0 busy 1", name); end
        tests_run++;
        if (t_valid !== 1'b1) begin tests_failed++; $display("FAIL %s t_valid: got %b expected 1", name, t_valid); end
        tests_run++;
        if (s_data !== es_data || s_sat !== es_sat) begin
            tests_failed++;
            $display("FAIL %s sat_data: got %0d sat %b expected %0d sat %b", name, s_data, s_sat, es_data, es_sat);
        end
        tests_run++;
        if (t_data !== et_data || t_sat !== et_sat) begin
            tests_failed++;
            $display("FAIL %s trunc_data: got %0d sat %b expected %0d sat %b", name, t_data, t_sat, et_data, et_sat);
        end
        tests_run++;
        if (s_rem !== e_rem || t_rem !== e_rem || s_div0 !== e_div0 || t_div0 !== e_div0) begin
            tests_failed++;
            $display("FAIL %s rem_div0: got %0d/%0d div0 %b/%b expected %0d div0 %b",
                     name, s_rem, t_rem, s_div0, t_div0, e_rem, e_div0);
        end
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            cycle();
            if (s_valid !== 1'b1 || s_data !== es_data || s_rem !== e_rem || s_sat !== es_sat ||
                s_div0 !== e_div0 || t_data !== et_data || s_rdreq !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) begin
            tests_run++;
            if (!stable) begin tests_failed++; $display("FAIL %s hold: got changing output expected stable for %0d cycles", name, hold); end
        end
        out_ready = 1'b1;
        cycle();
        tests_run++;
        if (s_valid !== 1'b0 || t_valid !== 1'b0 || s_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s handshake: got valid %b busy %b expected 0 0", name, s_valid, s_busy);
        end
        tests_run++;
        if (s_rdreq !== (enable && fifo_q.size() > 0)) begin
            tests_failed++;
            $display("FAIL %s next_rdreq: got %b expected %b", name, s_rdreq, (enable && fifo_q.size() > 0));
        end
    endtask

    task automatic test_reset();
        aclr_n = 1'b0; enable = 1'b1; out_ready = 1'b0; gain = 8'd0; denom = 8'd0;
        fifo_dataout = 8'd0; fifo_q.push_back(8'd77); fifo_empty = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({s_rdreq, s_valid, s_sat, s_div0, s_busy, t_rdreq, t_valid, t_busy} !== 8'd0 ||
            s_data !== 8'd0 || s_rem !== 8'd0 || t_data !== 8'd0 || t_rem !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got rdreq %b valid %b busy %b data %0d rem %0d expected all 0",
                     s_rdreq, s_valid, s_busy, s_data, s_rem);
        end
        aclr_n = 1'b1;
        #1;
        tests_run++;
        if (s_rdreq !== 1'b1 || t_rdreq !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_rdreq: got %b/%b expected 1", s_rdreq, t_rdreq);
        end
        enable = 1'b0; fifo_q.delete(); fifo_empty = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        bit bad;
        enable = 1'b1; bad = 1'b0;
        repeat (50) begin
            #1 if (s_rdreq !== 1'b0 || t_rdreq !== 1'b0 || s_busy !== 1'b0) bad = 1'b1;
            cycle();
        end
        tests_run++;
        if (bad) begin tests_failed++; $display("FAIL idle_empty: got rdreq or busy high expected 0"); end
        enable = 1'b0; fifo_q.push_back(8'd9); fifo_empty = 1'b0; bad = 1'b0;
        repeat (50) begin
            #1 if (s_rdreq !== 1'b0 || t_rdreq !== 1'b0 || s_busy !== 1'b0) bad = 1'b1;
            cycle();
        end
        tests_run++;
        if (bad) begin tests_failed++; $display("FAIL idle_disabled: got rdreq or busy high expected 0"); end
        fifo_q.delete(); fifo_empty = 1'b1;
    endtask

    task automatic test_directed();
        do_pixel("basic_100x3d2", 8'd100, 8'd3, 8'd2, 0, 1'b1, 1'b0);
        do_pixel("sat_255x255d1", 8'd255, 8'd255, 8'd1, 0, 1'b1, 1'b0);
        do_pixel("div0_37x7", 8'd37, 8'd7, 8'd0, 0, 1'b1, 1'b0);
        do_pixel("hold_200x1d3", 8'd200, 8'd1, 8'd3, 5, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] px[3];
        for (int i = 0; i < 3; i++) begin px[i] = 8'($urandom); fifo_q.push_back(px[i]); end
        fifo_empty = 1'b0;
        for (int i = 0; i < 3; i++)
            do_pixel("b2b", px[i], 8'($urandom), 8'($urandom_range(1, 255)), 0, 1'b0, 1'b0);
    endtask

    task automatic test_enable_drop();
        logic [7:0] a, b;
        a = 8'($urandom); b = 8'($urandom);
        fifo_q.push_back(a); fifo_q.push_back(b); fifo_empty = 1'b0;
        do_pixel("enable_drop", a, 8'd17, 8'd5, 2, 1'b0, 1'b1);
        do_pixel("enable_resume", b, 8'd2, 8'd0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 20; i++) begin
            d = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            do_pixel("random", 8'($urandom), 8'($urandom), d, $urandom_range(0, 3), 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  seen;
        fifo_q.push_back(8'd123); fifo_empty = 1'b0;
        gain = 8'd9; denom = 8'd7; enable = 1'b1; out_ready = 1'b1;
        #1; n = 0;
        while (s_rdreq !== 1'b1 && n < 20) begin cycle(); #1; n++; end
        repeat (5) cycle();
        enable = 1'b0;
        #2 aclr_n = 1'b0;
        #1;
        tests_run++;
        if ({s_valid, s_busy, s_rdreq, s_sat, s_div0, t_valid, t_busy} !== 7'd0 ||
            s_data !== 8'd0 || s_rem !== 8'd0 || t_data !== 8'd0 || t_rem !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: got valid %b busy %b data %0d rem %0d expected all 0",
                     s_valid, s_busy, s_data, s_rem);
        end
        @(negedge clk);
        aclr_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            cycle();
            if (s_valid !== 1'b0 || t_valid !== 1'b0 || s_busy !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin tests_failed++; $display("FAIL reset_discard: got output for discarded pixel expected none"); end
        do_pixel("after_reset", 8'd50, 8'd4, 8'd7, 1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle();
        test_back_to_back();
        test_enable_drop();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
